// File: rtl/disp_pkg.sv
// Shared types and segment patterns for the 7-segment display path (abcdefg, bit 6 = a).
package disp_pkg;

  typedef logic [3:0] bcd_t;
  typedef logic [6:0] seg_t;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } slot_state_t;

  localparam seg_t SEG_BLANK = 7'b0000000;

  // Positive-polarity patterns for digits 0..9.
  localparam seg_t DIGIT_PAT [0:9] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
    7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1110011
  };

endpackage

// File: rtl/bcd_display_scanner_if.sv
// Digit load bus in, pin-level anode/segment drive out; slave side is the scanner.
interface bcd_display_scanner_if #(
  parameter int N_DIGITS = 8
) ();

  logic [4*N_DIGITS-1:0] bcd_in;
  logic                  load;
  logic [N_DIGITS-1:0]   digit_en;
  logic [N_DIGITS-1:0]   anodes_n;
  logic [6:0]            seg_n;
  logic                  dp_n;
  logic                  slot_tick;

  modport master (
    output bcd_in, load, digit_en,
    input  anodes_n, seg_n, dp_n, slot_tick
  );

  modport slave (
    input  bcd_in, load, digit_en,
    output anodes_n, seg_n, dp_n, slot_tick
  );

endinterface

// File: rtl/bcd_display_scanner_seg7_decode_n.sv
// Combinational BCD to active-low segments; codes 10..15 come out fully dark.
module seg7_decode_n
  import disp_pkg::*;
(
  input  bcd_t bcd,
  output seg_t seg_n
);

  seg_t pat;

  always_comb begin
    pat = SEG_BLANK;
    for (int i = 0; i < 10; i++) begin
      if (bcd == i[3:0]) pat = DIGIT_PAT[i];
    end
  end

  assign seg_n = ~pat;

endmodule

// File: rtl/bcd_display_scanner.sv
// Multiplexed common-anode scanner: one digit per REFRESH_DIV-cycle slot, BLANK_CYCLES dark lead-in.
// Outputs registered (1 cycle); no backpressure, load is a fire-and-forget strobe.
// Optional LEADING_ZERO_BLANK_EN darkens leading zero digits above digit 0.
module bcd_display_scanner
  import disp_pkg::*;
#(
  parameter int N_DIGITS     = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input logic               clk,
  input logic               reset,
  bcd_display_scanner_if.slave bus
);

  localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = $clog2(N_DIGITS);

  typedef logic [PW-1:0] presc_t;
  typedef logic [IW-1:0] idx_t;

  localparam presc_t PRESC_LAST = presc_t'(REFRESH_DIV - 1);
  localparam presc_t BLANK_END  = presc_t'(BLANK_CYCLES);
  localparam idx_t   IDX_LAST   = idx_t'(N_DIGITS - 1);
  localparam slot_state_t RST_STATE = (BLANK_CYCLES == 0) ? SHOW : BLANK;

  logic [4*N_DIGITS-1:0] shadow_bcd;
  logic [N_DIGITS-1:0]   shadow_en;
  presc_t                presc, presc_nxt;
  idx_t                  index, index_nxt;
  logic                  presc_last;
  slot_state_t           state, state_nxt;

  logic [N_DIGITS-1:0]   lz_dark;
  logic [N_DIGITS-1:0]   show_mask;
  bcd_t                  cur_bcd;
  seg_t                  cur_seg_n;
  logic [N_DIGITS-1:0]   anodes_d;
  seg_t                  seg_d;

  // Shadow registers: the display runs from these, never from bcd_in directly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_bcd <= '0;
      shadow_en  <= '0;
    end else if (bus.load) begin
      shadow_bcd <= bus.bcd_in;
      shadow_en  <= bus.digit_en;
    end
  end

  assign presc_last = (presc == PRESC_LAST);
  assign presc_nxt  = presc_last ? '0 : presc_t'(presc + 1'b1);

  always_comb begin
    index_nxt = index;
    if (presc_last) index_nxt = (index == IDX_LAST) ? '0 : idx_t'(index + 1'b1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc <= '0;
      index <= '0;
    end else begin
      presc <= presc_nxt;
      index <= index_nxt;
    end
  end

  // Slot FSM mirrors the prescaler phase so the output stage can key off a state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RST_STATE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = SHOW;
    if (presc_nxt < BLANK_END) state_nxt = BLANK;
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic higher_zero;

  // Digit i is dark when it and every digit above it hold zero; digit 0 always shows.
  always_comb begin
    lz_dark     = '0;
    higher_zero = 1'b1;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      higher_zero = higher_zero & (shadow_bcd[4*i +: 4] == 4'd0);
      lz_dark[i]  = higher_zero;
    end
  end
`else
  assign lz_dark = '0;
`endif

  assign show_mask = shadow_en & ~lz_dark;
  assign cur_bcd   = shadow_bcd[{index, 2'b00} +: 4];

  seg7_decode_n u_decode (
    .bcd   (cur_bcd),
    .seg_n (cur_seg_n)
  );

  always_comb begin
    anodes_d = '1;
    seg_d    = '1;
    case (state)
      SHOW: begin
        if (show_mask[index]) anodes_d[index] = 1'b0;
        seg_d = cur_seg_n;
      end
      default: begin
        anodes_d = '1;
        seg_d    = '1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.anodes_n  <= '1;
      bus.seg_n     <= '1;
      bus.slot_tick <= 1'b0;
    end else begin
      bus.anodes_n  <= anodes_d;
      bus.seg_n     <= seg_d;
      bus.slot_tick <= presc_last;
    end
  end

  assign bus.dp_n = 1'b1;

endmodule
